// File: rtl/sprite_key_driver.sv
// sprite_key_driver
//   Produces the per-frame movement keycode for the sprite movement logic.
//   Raw keyboard codes are filtered to the four direction keys; a new press
//   is emitted once, then after a hold delay the key auto-repeats. When the
//   keyboard has been idle long enough (and the demo is permitted) a square
//   "attract" path is played. One update per frame_clk edge, all outputs
//   registered (one frame of latency from keycode_in).
//
// Ports
//   frame_clk    in   1  frame clock, one rising edge per video frame
//   Reset        in   1  asynchronous, active-high reset
//   keycode_in   in   8  raw keyboard keycode
//   demo_en      in   1  1 = idle-timeout demo permitted
//   keycode_out  out  8  04 left, 07 right, 16 down, 1A up, 00 none
//   key_valid    out  1  keycode_out != 0
//   demo_active  out  1  1 while playing the demo path
module sprite_key_driver #(
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE  = 1,
  parameter int IDLE_TIMEOUT = 600,
  parameter int DEMO_LEG     = 60,
  parameter int CNT_W        = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  input  logic       demo_en,
  output logic [7:0] keycode_out,
  output logic       key_valid,
  output logic       demo_active
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] LEG_LAST   = CNT_W'(DEMO_LEG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_DEMO
  } state_t;

  state_t           r_state;
  logic [7:0]       r_held;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_leg;

  state_t           w_state;
  logic [7:0]       w_out;
  logic [7:0]       w_held;
  logic [CNT_W-1:0] w_cnt;
  logic [1:0]       w_leg;
  logic             w_key_ok;
  logic             w_press;

  // Square path, clockwise starting rightwards.
  function automatic logic [7:0] f_demo_dir(input logic [1:0] leg);
    case (leg)
      2'd0:    f_demo_dir = KEY_RIGHT;
      2'd1:    f_demo_dir = KEY_DOWN;
      2'd2:    f_demo_dir = KEY_LEFT;
      default: f_demo_dir = KEY_UP;
    endcase
  endfunction

  assign w_key_ok = (keycode_in == KEY_LEFT) || (keycode_in == KEY_RIGHT) ||
                    (keycode_in == KEY_DOWN) || (keycode_in == KEY_UP);

  // From IDLE/DEMO any valid key is a fresh press; elsewhere only a change.
  assign w_press = w_key_ok &&
                   ((r_state == S_IDLE) || (r_state == S_DEMO) || (keycode_in != r_held));

  always_comb begin
    w_state = r_state;
    w_out   = 8'h00;
    w_held  = r_held;
    w_cnt   = r_cnt;
    w_leg   = r_leg;
    if (w_press) begin
      w_state = S_DELAY;
      w_out   = keycode_in;
      w_held  = keycode_in;
      w_cnt   = '0;
      w_leg   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (demo_en && (r_cnt == IDLE_LAST)) begin
            w_state = S_DEMO;
            w_out   = KEY_RIGHT;
            w_cnt   = '0;
            w_leg   = 2'd0;
          end else if (r_cnt != IDLE_LAST) begin
            // Saturate so a late demo_en rise starts the demo immediately.
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        S_DELAY: begin
          if (!w_key_ok) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else if (r_cnt == DELAY_LAST) begin
            w_state = S_REPEAT;
            w_out   = r_held;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        S_REPEAT: begin
          if (!w_key_ok) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else if (r_cnt == RATE_LAST) begin
            w_out = r_held;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        S_DEMO: begin
          if (!demo_en) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_leg   = 2'd0;
          end else if (r_cnt == LEG_LAST) begin
            w_cnt = '0;
            w_leg = r_leg + 2'd1;
            w_out = f_demo_dir(w_leg);
          end else begin
            w_cnt = r_cnt + CNT_ONE;
            w_out = f_demo_dir(r_leg);
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_held      <= 8'h00;
      r_cnt       <= '0;
      r_leg       <= 2'd0;
      keycode_out <= 8'h00;
      key_valid   <= 1'b0;
      demo_active <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_held      <= w_held;
      r_cnt       <= w_cnt;
      r_leg       <= w_leg;
      keycode_out <= w_out;
      key_valid   <= (w_out != 8'h00);
      demo_active <= (w_state == S_DEMO);
    end
  end

endmodule
